muldiv_unit: RTL and testbench

- Parametrised, multi-cycle RV32M/RV64M multiply/divide unit. It sits beside the single-cycle ALU in the EX stage.
- The pipeline issues an operation with a valid/ready handshake and stalls on in_ready low.
- The unit computes the result iteratively, one bit per cycle, then holds it until writeback accepts it.
- A destination tag travels with each operation so the hazard logic can match the result to its register.

---
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one bit per cycle, valid/ready on both sides.
// State | meaning: IDLE waits for an op, PREP forms operand magnitudes, CALC iterates, DONE holds the result.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       SELECT,
    input  logic [XLEN-1:0]  DATA1,
    input  logic [XLEN-1:0]  DATA2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  RESULT,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} state_t;

    state_t              state;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     a_q, b_q, divisor;
    logic [TAG_W-1:0]    tag_q;
    logic                neg_q;
    logic [2*XLEN-1:0]   acc;
    logic [CW-1:0]       cnt;

    logic                a_sgn, b_sgn, neg_nx;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic                special;
    logic [XLEN-1:0]     special_res;
    logic [XLEN:0]       mul_sum, rem_sh, diff;
    logic [2*XLEN-1:0]   acc_nx, prod_fix;
    logic [XLEN-1:0]     quot, rmd, final_res;

    assign in_ready = (state == IDLE) && !flush;
    assign busy     = (state != IDLE);

    // Operand signedness and result sign, from the operands latched at accept.
    always_comb begin
        a_sgn  = a_q[XLEN-1] && (op_q == OP_MULH || op_q == OP_MULHSU ||
                                 op_q == OP_DIV  || op_q == OP_REM);
        b_sgn  = b_q[XLEN-1] && (op_q == OP_MULH || op_q == OP_DIV || op_q == OP_REM);
        abs_a  = a_sgn ? -a_q : a_q;
        abs_b  = b_sgn ? -b_q : b_q;
        neg_nx = (op_q == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);
    end

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    always_comb begin
        special     = 1'b0;
        special_res = '0;
        if (SELECT[2]) begin
            if (DATA2 == '0) begin
                special     = 1'b1;
                special_res = SELECT[1] ? DATA1 : '1;
            end else if (!SELECT[0] && DATA1 == {1'b1, {(XLEN-1){1'b0}}} && DATA2 == '1) begin
                special     = 1'b1;
                special_res = SELECT[1] ? '0 : DATA1;
            end
        end
    end

    // acc holds {partial product high, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, divisor} : '0);
        rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff    = rem_sh - {1'b0, divisor};
        if (!op_q[2])
            acc_nx = {mul_sum, acc[XLEN-1:1]};
        else if (!diff[XLEN])
            acc_nx = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_nx = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end

    always_comb begin
        prod_fix = neg_q ? -acc_nx : acc_nx;
        quot     = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
        rmd      = neg_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
        if (!op_q[2])
            final_res = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else
            final_res = op_q[1] ? rmd : quot;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            divisor   <= '0;
            tag_q     <= '0;
            neg_q     <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            RESULT    <= '0;
            out_tag   <= '0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q  <= SELECT;
                        a_q   <= DATA1;
                        b_q   <= DATA2;
                        tag_q <= in_tag;
                        if (special) begin
                            RESULT    <= special_res;
                            out_tag   <= in_tag;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= PREP;
                        end
                    end
                end
                PREP: begin
                    acc     <= {{XLEN{1'b0}}, abs_a};
                    divisor <= abs_b;
                    neg_q   <= neg_nx;
                    cnt     <= CW'(XLEN);
                    state   <= CALC;
                end
                CALC: begin
                    acc <= acc_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        RESULT    <= final_res;
                        out_tag   <= tag_q;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32): results, latency, handshake hold, flush and reset abort.
module tb_muldiv_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic             CLK = 1'b0;
    logic             RESET = 1'b1;
    logic             in_valid = 1'b0;
    logic             flush = 1'b0;
    logic             out_ready = 1'b1;
    logic [2:0]       SELECT = '0;
    logic [XLEN-1:0]  DATA1 = '0;
    logic [XLEN-1:0]  DATA2 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             in_ready, out_valid, busy;
    logic [XLEN-1:0]  RESULT;
    logic [TAG_W-1:0] out_tag;

    int n_assert = 0;
    int n_fail   = 0;
    logic [XLEN-1:0] last_result = '0;

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
        .SELECT(SELECT), .DATA1(DATA1), .DATA2(DATA2), .in_tag(in_tag),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .RESULT(RESULT), .out_tag(out_tag), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    // Drives one request on a falling edge; returns just after the accept edge with operands scrambled.
    task automatic start_op(input string name, input logic [2:0] sel, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [4:0] tg);
        @(negedge CLK);
        check({name, "_in_ready_pre"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        SELECT   = sel;
        DATA1    = d1;
        DATA2    = d2;
        in_tag   = tg;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        DATA1    = $urandom;
        DATA2    = $urandom;
        SELECT   = ~sel;
        in_tag   = ~tg;
    endtask

    task automatic run_op(input string name, input logic [2:0] sel, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [4:0] tg, input logic [31:0] exp_res,
                          input int exp_lat, input int hold);
        int lat = 0;
        bit rdy_low = 1'b1;
        bit stable = 1'b1;
        logic [31:0] r0;
        logic [4:0]  t0;
        out_ready = (hold == 0);
        start_op(name, sel, d1, d2, tg);
        for (int c = 1; c <= 60; c++) begin
            @(negedge CLK);
            if (in_ready) rdy_low = 1'b0;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_result"}, 64'(RESULT), 64'(exp_res));
        check({name, "_tag"}, 64'(out_tag), 64'(tg));
        check({name, "_in_ready_low"}, 64'(rdy_low), 64'd1);
        if (hold > 0) begin
            r0 = RESULT;
            t0 = out_tag;
            for (int c = 0; c < hold; c++) begin
                @(negedge CLK);
                if (RESULT !== r0 || out_tag !== t0 || in_ready !== 1'b0 || out_valid !== 1'b1)
                    stable = 1'b0;
            end
            check({name, "_hold_stable"}, 64'(stable), 64'd1);
            out_ready = 1'b1;
        end
        @(negedge CLK);
        check({name, "_out_valid_drop"}, 64'(out_valid), 64'd0);
        check({name, "_in_ready_post"}, 64'(in_ready), 64'd1);
        last_result = exp_res;
    endtask

    initial begin
        bit quiet;
        repeat (3) @(negedge CLK);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(RESULT), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        run_op("mul",     3'b000, 32'd7,        32'hFFFFFFFD, 5'h0A, 32'hFFFFFFEB, 34, 0);
        run_op("mulh",    3'b001, 32'h80000000, 32'h80000000, 5'h01, 32'h40000000, 34, 0);
        run_op("mulhu",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h02, 32'hFFFFFFFE, 34, 0);
        run_op("mulhsu",  3'b010, 32'hFFFFFFFF, 32'h00000002, 5'h03, 32'hFFFFFFFF, 34, 0);
        run_op("div",     3'b100, 32'hFFFFFFF9, 32'd2,        5'h04, 32'hFFFFFFFD, 34, 0);
        run_op("rem",     3'b110, 32'hFFFFFFF9, 32'd2,        5'h05, 32'hFFFFFFFF, 34, 0);
        run_op("divu",    3'b101, 32'hFFFFFFF9, 32'd2,        5'h06, 32'h7FFFFFFC, 34, 0);
        run_op("remu",    3'b111, 32'hFFFFFFF9, 32'd2,        5'h07, 32'h00000001, 34, 0);
        run_op("div_z",   3'b100, 32'd5,        32'd0,        5'h08, 32'hFFFFFFFF, 1, 0);
        run_op("remu_z",  3'b111, 32'd5,        32'd0,        5'h09, 32'h00000005, 1, 0);
        run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'h0B, 32'h80000000, 1, 0);
        run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'h0C, 32'h00000000, 1, 0);
        run_op("divu_hold", 3'b101, 32'd100,    32'd7,        5'h1D, 32'h0000000E, 34, 10);

        // Flush during CALC with a competing request: no accept, no result, RESULT retained.
        start_op("flush", 3'b000, 32'd7, 32'd9, 5'h11);
        repeat (11) @(negedge CLK);
        flush    = 1'b1;
        in_valid = 1'b1;
        SELECT   = 3'b101;
        DATA1    = 32'd50;
        DATA2    = 32'd5;
        in_tag   = 5'h12;
        #1;
        check("flush_in_ready_gated", 64'(in_ready), 64'd0);
        @(posedge CLK);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge CLK);
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_result_kept", 64'(RESULT), 64'(last_result));
        quiet = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (out_valid || busy) quiet = 1'b0;
        end
        check("flush_no_result", 64'(quiet), 64'd1);

        // Reset mid-operation also clears RESULT and out_tag.
        start_op("reset", 3'b000, 32'd7, 32'd9, 5'h13);
        repeat (11) @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("midrst_result", 64'(RESULT), 64'd0);
        check("midrst_out_tag", 64'(out_tag), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);

        run_op("mul_3x4", 3'b000, 32'd3, 32'd4, 5'h14, 32'd12, 34, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
